// File: rtl/sample_packer.sv
// -----------------------------------------------------------------------------
// sample_packer
//   Quantizes three channels of 8-bit complex samples to 2-bit sign/magnitude
//   I/Q codes (12-bit sample code) and bit-packs four codes into three 16-bit
//   words, MSB first. Feeds source_data/source_en of the packet streamer.
//
//   Pipeline: input capture (acceptance) -> quantizer stage -> packer/output.
//
// Ports:
//   clk           ADC-domain clock
//   reset         synchronous, active-high reset
//   in_valid      sample strobe
//   chN_i/chN_q   signed 8-bit components, N = 0..2
//   threshold     7-bit unsigned magnitude threshold, captured with each sample
//   enable        packing enable; low clears the partial group and holds idle
//   test_mode     (PACKER_TEST_PATTERN_EN only) emit word counter instead of data
//   out_data      packed 16-bit word
//   out_en        one-cycle strobe per word
//   sample_count  accepted-sample count, wraps modulo 2^32
//
// Build option: define PACKER_TEST_PATTERN_EN to add test_mode and the word
// counter test pattern.
// -----------------------------------------------------------------------------
module sample_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  ch0_i,
  input  logic [7:0]  ch0_q,
  input  logic [7:0]  ch1_i,
  input  logic [7:0]  ch1_q,
  input  logic [7:0]  ch2_i,
  input  logic [7:0]  ch2_q,
  input  logic [6:0]  threshold,
  input  logic        enable,
`ifdef PACKER_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic [15:0] out_data,
  output logic        out_en,
  output logic [31:0] sample_count
);

  // 2-bit code {sign, |x| >= t}; |x| is 9 bits wide so -128 maps to 128.
  function automatic logic [1:0] quant(input logic [7:0] x, input logic [6:0] t);
    logic [8:0] ax;
    ax = x[7] ? (9'd0 - {x[7], x}) : {1'b0, x};
    return {x[7], (ax >= {2'b00, t})};
  endfunction

  logic        accept;
  logic        in_vld_q;
  logic [47:0] in_smp_q;
  logic [6:0]  thr_q;
  logic [31:0] cnt_q;

  logic        code_vld_q;
  logic [11:0] code_q;
  logic [11:0] code_d;

  logic [1:0]  phase_q, phase_d;
  logic [23:0] residue_q, residue_d;
  logic [15:0] out_data_q, out_data_d;
  logic        out_en_q, out_en_d;
  logic [23:0] combined;
  logic [4:0]  shamt;

  assign accept = in_valid && enable;

  // Acceptance: capture raw components and threshold.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_vld_q <= 1'b0;
      in_smp_q <= '0;
      thr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      in_vld_q <= accept;
      if (accept) begin
        in_smp_q <= {ch0_i, ch0_q, ch1_i, ch1_q, ch2_i, ch2_q};
        thr_q    <= threshold;
        cnt_q    <= cnt_q + 32'd1;
      end
    end
  end

  always_comb begin
    code_d = {quant(in_smp_q[47:40], thr_q), quant(in_smp_q[39:32], thr_q),
              quant(in_smp_q[31:24], thr_q), quant(in_smp_q[23:16], thr_q),
              quant(in_smp_q[15:8],  thr_q), quant(in_smp_q[7:0],   thr_q)};
  end

  // Quantizer stage; enable low drops anything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      code_vld_q <= 1'b0;
      code_q     <= '0;
    end else begin
      code_vld_q <= in_vld_q && enable;
      if (in_vld_q) code_q <= code_d;
    end
  end

  // The residue is left-aligned; the new code is ORed in just below the
  // leftover bits, the top 16 bits form the word, and the remainder shifts up.
  always_comb begin
    case (phase_q)
      2'd0:    shamt = 5'd12;
      2'd1:    shamt = 5'd0;
      2'd2:    shamt = 5'd4;
      default: shamt = 5'd8;
    endcase
    combined = residue_q | ({12'd0, code_q} << shamt);
  end

`ifdef PACKER_TEST_PATTERN_EN
  logic [15:0] word_cnt_q;
  logic [15:0] word_src;
  always_ff @(posedge clk) begin
    if (reset || !enable)  word_cnt_q <= '0;
    else if (out_en_d)     word_cnt_q <= word_cnt_q + 16'd1;
  end
  assign word_src = test_mode ? word_cnt_q : combined[23:8];
`else
  logic [15:0] word_src;
  assign word_src = combined[23:8];
`endif

  always_comb begin
    phase_d    = phase_q;
    residue_d  = residue_q;
    out_data_d = out_data_q;
    out_en_d   = 1'b0;
    if (!enable) begin
      phase_d   = 2'd0;
      residue_d = '0;
    end else if (code_vld_q) begin
      phase_d = phase_q + 2'd1;
      if (phase_q == 2'd0) begin
        residue_d = combined;
      end else begin
        residue_d  = (phase_q == 2'd3) ? 24'd0 : (combined << 16);
        out_data_d = word_src;
        out_en_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= '0;
      residue_q  <= '0;
      out_data_q <= '0;
      out_en_q   <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      residue_q  <= residue_d;
      out_data_q <= out_data_d;
      out_en_q   <= out_en_d;
    end
  end

  assign out_data     = out_data_q;
  assign out_en       = out_en_q;
  assign sample_count = cnt_q;

endmodule
